// File: rtl/mac_pipe.sv
// ---------------------------------------------------------------------------
// mac_pipe -- two-stage pipelined signed multiply-accumulate unit.
//
// Stage 1 registers the opcode, the full signed DW x DW product and a valid
// bit when an instruction is accepted (in_valid=1, stall=0). Stage 2 applies
// the registered operation to the accumulator on the next unstalled edge.
// The accumulator carries GW guard bits above the 2*DW product width.
//
// Parameters
//   DW           signed operand width
//   GW           accumulator guard bits (accumulator width AW = 2*DW+GW)
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_valid     instruction/operands valid this cycle
//   instruction  3-bit opcode
//   multiplier   two's-complement operand A
//   multiplicand two's-complement operand B
//   stall        freeze the entire pipeline
//   result       accumulator bits [2*DW-1:0]
//   protect      accumulator guard bits [AW-1:2*DW]
//   out_valid    accumulator was updated by a completed instruction
//   ovf          sticky signed accumulator wrap flag
// ---------------------------------------------------------------------------
module mac_pipe #(
    parameter int DW = 16,
    parameter int GW = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [2:0]        instruction,
    input  logic [DW-1:0]     multiplier,
    input  logic [DW-1:0]     multiplicand,
    input  logic              stall,
    output logic [2*DW-1:0]   result,
    output logic [GW-1:0]     protect,
    output logic              out_valid,
    output logic              ovf
);

    localparam int PW = 2 * DW;
    localparam int AW = PW + GW;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_MAC  = 3'b010,
        OP_SAT  = 3'b011,
        OP_CLR  = 3'b100,
        OP_MSUB = 3'b101,
        OP_NOP2 = 3'b110,
        OP_CLR2 = 3'b111
    } opcode_t;

    // Saturation bounds of the 2*DW-bit signed range, sign-extended to AW.
    localparam logic [AW-1:0] SAT_MAX = {{(GW + 1){1'b0}}, {(PW - 1){1'b1}}};
    localparam logic [AW-1:0] SAT_MIN = {{(GW + 1){1'b1}}, {(PW - 1){1'b0}}};

    logic            s1_valid;
    opcode_t         s1_op;
    logic [PW-1:0]   s1_prod;
    logic [PW-1:0]   prod_c;

    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_next;
    logic            ovf_next;
    logic [AW-1:0]   prod_ext;
    logic [AW:0]     sum_wide;
    logic [AW:0]     diff_wide;
    logic            in_range;

    // Full-width signed product; the most negative squared is representable.
    assign prod_c = $signed(multiplier) * $signed(multiplicand);

    // Stage 1: capture opcode and product on acceptance. A bubble only
    // clears the valid bit; stale opcode/product are never used.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_NOP;
            s1_prod  <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= opcode_t'(instruction);
                s1_prod <= prod_c;
            end
        end
    end

    // One extra bit on the add/subtract exposes signed overflow: the top
    // two bits of the wide result disagree exactly when AW bits wrapped.
    assign prod_ext  = {{GW{s1_prod[PW-1]}}, s1_prod};
    assign sum_wide  = {acc[AW-1], acc} + {prod_ext[AW-1], prod_ext};
    assign diff_wide = {acc[AW-1], acc} - {prod_ext[AW-1], prod_ext};

    // Value fits in 2*DW signed bits when all bits from the 2*DW-1 sign
    // position upward are identical.
    assign in_range = (&acc[AW-1:PW-1]) | ~(|acc[AW-1:PW-1]);

    // Stage 2 next-state: what the accumulator and sticky flag become if
    // the instruction held in stage 1 completes on this edge.
    always_comb begin
        acc_next = acc;
        ovf_next = ovf;
        case (s1_op)
            OP_LOAD: begin
                acc_next = prod_ext;
                ovf_next = 1'b0;
            end
            OP_MAC: begin
                acc_next = sum_wide[AW-1:0];
                if (sum_wide[AW] != sum_wide[AW-1])
                    ovf_next = 1'b1;
            end
            OP_MSUB: begin
                acc_next = diff_wide[AW-1:0];
                if (diff_wide[AW] != diff_wide[AW-1])
                    ovf_next = 1'b1;
            end
            OP_SAT: begin
                if (!in_range)
                    acc_next = acc[AW-1] ? SAT_MIN : SAT_MAX;
            end
            OP_CLR, OP_CLR2: begin
                acc_next = '0;
                ovf_next = 1'b0;
            end
            default: begin
                acc_next = acc;
                ovf_next = ovf;
            end
        endcase
    end

    // Stage 2 registers. out_valid marks the cycle after any valid
    // instruction (NOP included) completes; stall freezes everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                acc <= acc_next;
                ovf <= ovf_next;
            end
        end
    end

    assign result  = acc[PW-1:0];
    assign protect = acc[AW-1:PW];

endmodule

// File: tb/tb_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_mac_pipe -- directed self-checking bench for mac_pipe (DW=16, GW=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mac_pipe;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] MAC  = 3'b010;
    localparam logic [2:0] SAT  = 3'b011;
    localparam logic [2:0] CLR  = 3'b100;
    localparam logic [2:0] MSUB = 3'b101;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [2:0]  instruction;
    logic [15:0] multiplier;
    logic [15:0] multiplicand;
    logic        stall;
    logic [31:0] result;
    logic [7:0]  protect;
    logic        out_valid;
    logic        ovf;

    int compared;
    int mismatched;

    mac_pipe #(.DW(16), .GW(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .instruction  (instruction),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .stall        (stall),
        .result       (result),
        .protect      (protect),
        .out_valid    (out_valid),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then advances to just after the next edge.
    task automatic applyStimulus(input logic v, input logic [2:0] op,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic s);
        in_valid     = v;
        instruction  = op;
        multiplier   = a;
        multiplicand = b;
        stall        = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, NOP, 16'h0000, 16'h0000, 1'b0);
    endtask

    function automatic logic [63:0] acc_now();
        return 64'({protect, result});
    endfunction

    initial begin
        compared     = 0;
        mismatched   = 0;
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        instruction  = NOP;
        multiplier   = '0;
        multiplicand = '0;
        stall        = 1'b0;

        // Reset state
        #2;
        checkOutput("reset_acc", acc_now(), 64'h0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'h0);
        checkOutput("reset_ovf", 64'(ovf), 64'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // LOAD -3 * 5, visible two edges after acceptance for one cycle
        applyStimulus(1'b1, LOAD, 16'hFFFD, 16'h0005, 1'b0);
        checkOutput("load_latency_valid", 64'(out_valid), 64'h0);
        checkOutput("load_latency_acc", acc_now(), 64'h0);
        idle();
        checkOutput("load_result", 64'(result), 64'hFFFF_FFF1);
        checkOutput("load_protect", 64'(protect), 64'hFF);
        checkOutput("load_out_valid", 64'(out_valid), 64'h1);
        idle();
        checkOutput("load_out_valid_drop", 64'(out_valid), 64'h0);
        checkOutput("load_acc_hold", acc_now(), 64'hFF_FFFF_FFF1);

        // CLR, three back-to-back MACs of 0x7FFF^2, then positive SAT
        applyStimulus(1'b1, CLR, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(1'b1, MAC, 16'h7FFF, 16'h7FFF, 1'b0);
        applyStimulus(1'b1, MAC, 16'h7FFF, 16'h7FFF, 1'b0);
        checkOutput("mac1_acc", acc_now(), 64'h00_3FFF_0001);
        applyStimulus(1'b1, MAC, 16'h7FFF, 16'h7FFF, 1'b0);
        checkOutput("mac2_acc", acc_now(), 64'h00_7FFE_0002);
        applyStimulus(1'b1, SAT, 16'h0000, 16'h0000, 1'b0);
        checkOutput("mac3_result", 64'(result), 64'hBFFD_0003);
        checkOutput("mac3_protect", 64'(protect), 64'h00);
        idle();
        checkOutput("sat_pos_result", 64'(result), 64'h7FFF_FFFF);
        checkOutput("sat_pos_protect", 64'(protect), 64'h00);
        checkOutput("sat_pos_ovf", 64'(ovf), 64'h0);

        // Most-negative squared, MSUB, then SAT on an in-range value
        applyStimulus(1'b1, LOAD, 16'h8000, 16'h8000, 1'b0);
        applyStimulus(1'b1, MSUB, 16'h0001, 16'h0001, 1'b0);
        checkOutput("minsq_acc", acc_now(), 64'h00_4000_0000);
        applyStimulus(1'b1, SAT, 16'h0000, 16'h0000, 1'b0);
        checkOutput("msub_acc", acc_now(), 64'h00_3FFF_FFFF);
        idle();
        checkOutput("sat_inrange_acc", acc_now(), 64'h00_3FFF_FFFF);

        // Negative accumulation below the 32-bit range, then SAT to minimum
        applyStimulus(1'b1, LOAD, 16'h8000, 16'h7FFF, 1'b0);
        applyStimulus(1'b1, MAC, 16'h8000, 16'h7FFF, 1'b0);
        checkOutput("neg_load_acc", acc_now(), 64'hFF_C000_8000);
        applyStimulus(1'b1, MAC, 16'h8000, 16'h7FFF, 1'b0);
        applyStimulus(1'b1, MAC, 16'h8000, 16'h7FFF, 1'b0);
        applyStimulus(1'b1, SAT, 16'h0000, 16'h0000, 1'b0);
        checkOutput("neg_mac_acc", acc_now(), 64'hFF_0002_0000);
        idle();
        checkOutput("sat_neg_result", 64'(result), 64'h8000_0000);
        checkOutput("sat_neg_protect", 64'(protect), 64'hFF);

        // Stall for 3 cycles right after a MAC is accepted
        applyStimulus(1'b1, LOAD, 16'h0002, 16'h0003, 1'b0);
        idle();
        idle();
        checkOutput("pre_stall_acc", acc_now(), 64'h6);
        applyStimulus(1'b1, MAC, 16'h0004, 16'h0005, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, CLR, 16'h1234, 16'h5678, 1'b1);
            checkOutput("stall_acc", acc_now(), 64'h6);
            checkOutput("stall_out_valid", 64'(out_valid), 64'h0);
        end
        idle();
        checkOutput("post_stall_acc", acc_now(), 64'd26);
        checkOutput("post_stall_out_valid", 64'(out_valid), 64'h1);

        // Asynchronous reset with two MACs in flight
        applyStimulus(1'b1, MAC, 16'h0001, 16'h0001, 1'b0);
        applyStimulus(1'b1, MAC, 16'h0001, 16'h0001, 1'b0);
        checkOutput("inflight_acc", acc_now(), 64'd27);
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_acc", acc_now(), 64'h0);
        checkOutput("async_reset_out_valid", 64'(out_valid), 64'h0);
        checkOutput("async_reset_ovf", 64'(ovf), 64'h0);
        #1;
        reset_n = 1'b1;
        idle();
        checkOutput("post_reset_acc1", acc_now(), 64'h0);
        checkOutput("post_reset_out_valid", 64'(out_valid), 64'h0);
        idle();
        checkOutput("post_reset_acc2", acc_now(), 64'h0);

        // First instruction after reset works from a zero accumulator
        applyStimulus(1'b1, MAC, 16'h0003, 16'hFFFE, 1'b0);
        idle();
        checkOutput("first_after_reset", acc_now(), 64'hFF_FFFF_FFFA);

        // Repeated 2^30 accumulation until signed 40-bit wrap
        applyStimulus(1'b1, CLR, 16'h0000, 16'h0000, 1'b0);
        for (int i = 1; i <= 513; i++) begin
            applyStimulus(1'b1, MAC, 16'h8000, 16'h8000, 1'b0);
            if (i == 512) begin
                checkOutput("pre_wrap_acc", acc_now(), 64'h7F_C000_0000);
                checkOutput("pre_wrap_ovf", 64'(ovf), 64'h0);
            end else if (i == 513) begin
                checkOutput("wrap_protect", 64'(protect), 64'h80);
                checkOutput("wrap_result", 64'(result), 64'h0);
                checkOutput("wrap_ovf", 64'(ovf), 64'h1);
            end
        end
        applyStimulus(1'b1, CLR, 16'h0000, 16'h0000, 1'b0);
        checkOutput("sticky_acc", acc_now(), 64'h80_4000_0000);
        checkOutput("sticky_ovf", 64'(ovf), 64'h1);
        idle();
        checkOutput("clr_acc", acc_now(), 64'h0);
        checkOutput("clr_ovf", 64'(ovf), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mac_pipe.md
MAC_PIPE -- requirements
Module: mac_pipe

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning signed operand width.
REQ-002 The block SHALL have parameter GW, default 8, meaning accumulator guard bits; AW = 2*DW+GW.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, instruction/operands valid this cycle.
REQ-006 The block SHALL have port instruction, input, 3, opcode.
REQ-007 The block SHALL have port multiplier, input, DW, two's-complement operand A.
REQ-008 The block SHALL have port multiplicand, input, DW, two's-complement operand B.
REQ-009 The block SHALL have port stall, input, 1, freeze entire pipeline.
REQ-010 The block SHALL have port result, output, 2*DW, accumulator bits [2*DW-1:0].
REQ-011 The block SHALL have port protect, output, GW, accumulator guard bits [AW-1:2*DW].
REQ-012 The block SHALL have port out_valid, output, 1, accumulator updated by a completed instruction.
REQ-013 The block SHALL have port ovf, output, 1, sticky accumulator wrap flag.

Function
REQ-014 Opcodes SHALL be: 000 NOP, 001 LOAD (acc=A*B), 010 MAC (acc+=A*B), 011 SAT, 100 CLR, 101 MSUB (acc-=A*B), 110 NOP, 111 CLR.
REQ-015 Products SHALL be full signed DW x DW -> 2*DW, sign-extended to AW; -2^(DW-1) * -2^(DW-1) yields +2^(2*DW-2) exactly.
REQ-016 An instruction SHALL be accepted on a rising edge with in_valid=1 and stall=0; stage 1 registers opcode, product and a valid bit on that edge.
REQ-017 Stage 2 SHALL update the accumulator on the next unstalled edge; latency accept-to-updated-output is 2 unstalled edges.
REQ-018 {protect,result} SHALL always equal the accumulator register; no separate output register.
REQ-019 out_valid SHALL be registered, high for the cycle following each stage-2 update of a valid instruction (NOP included), low otherwise.
REQ-020 Back-to-back instructions SHALL accept every cycle; each stage-2 operation uses the accumulator produced by the previous instruction (no bubbles, no hazards).
REQ-021 MAC/MSUB/LOAD arithmetic SHALL be modulo 2^AW; on signed AW overflow ovf SHALL be set and the accumulator wraps.
REQ-022 SAT SHALL clamp acc to [-2^(2*DW-1), 2^(2*DW-1)-1], sign-extended through guard bits; in-range values are unchanged.
REQ-023 CLR SHALL zero the accumulator and clear ovf; LOAD SHALL clear ovf before its write.
REQ-024 stall=1 SHALL hold every register (both stages, accumulator, out_valid, ovf); inputs are ignored.
REQ-025 in_valid=0 with stall=0 SHALL insert a bubble: stage-2 valid cleared, accumulator unchanged.

Reset
REQ-026 reset_n=0 SHALL immediately clear accumulator, result, protect, ovf, out_valid and both stage-valid bits, discarding in-flight instructions.
REQ-027 After reset release the first accepted instruction SHALL behave as from an all-zero accumulator.

Verification (DW=16, GW=8)
REQ-028 LOAD A=-3, B=5 -> 2 edges later result=0xFFFFFFF1, protect=0xFF, out_valid=1 for one cycle.
REQ-029 CLR then 3 consecutive MAC 0x7FFF*0x7FFF -> result=0xBFFD0003, protect=0x00; then SAT -> result=0x7FFFFFFF, protect=0x00, ovf=0.
REQ-030 LOAD 0x8000*0x8000 -> result=0x40000000, protect=0x00; then MSUB 0x0001*0x0001 -> result=0x3FFFFFFF.
REQ-031 MAC issued, stall=1 for 3 cycles after acceptance -> accumulator, out_valid unchanged during stall; update appears 1 edge after stall drops.
REQ-032 Two MACs in flight, reset_n pulsed low mid-cycle -> all outputs 0 asynchronously, no update after release.
REQ-033 Repeated MAC 0x8000*0x8000 until acc exceeds 2^39-1 -> ovf=1, acc wrapped modulo 2^40; CLR -> ovf=0, acc=0.
